instr_fetch_sequencer: RTL and testbench

- Sequences a byte-wide, synchronous-read instruction memory. Assembles one 32-bit big-endian instruction from four consecutive bytes per fetch.
- Shares the memory's single port between the core's fetch path and a program-load path that writes bytes before or between fetches.
- Sits between the PC/control logic and the instruction byte memory, replacing direct combinational indexing.

---
 rtl/instr_fetch_sequencer_pkg.sv | 15 +
 rtl/instr_fetch_sequencer_assembler.sv | 27 ++
 rtl/instr_fetch_sequencer.sv | 129 ++++++++++++
 tb/tb_instr_fetch_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM encoding,
// instruction geometry and the byte counter width.
package instr_fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    LAST = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  localparam int BYTES_PER_INSTR = 4;
  localparam int CNT_W           = 2;

endpackage

// File: rtl/instr_fetch_sequencer_assembler.sv
// Four 8-bit lanes that build one big-endian instruction word; lane 0 is the
// byte at the lowest address and lands in bits [31:24].
module instr_byte_assembler
  import instr_fetch_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [CNT_W-1:0] lane,
  input  logic [7:0]       din,
  output logic [31:0]      word
);

  logic [7:0] lanes [BYTES_PER_INSTR];

  // Lane register: synchronous clear wins over a lane write.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < BYTES_PER_INSTR; i++) lanes[i] <= '0;
    end else if (we) begin
      lanes[lane] <= din;
    end
  end

  assign word = {lanes[0], lanes[1], lanes[2], lanes[3]};

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Shares a byte-wide synchronous-read instruction memory between program
// loading and 4-byte instruction fetches, assembling big-endian words.
module instr_fetch_sequencer
  import instr_fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_pc,
  input  logic              fetch_ready,
  output logic [31:0]       instruction,
  output logic              instr_valid,
  output logic              misaligned,
  output logic              fetch_busy,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_byte,
  output logic              load_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  fetch_state_t      state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] base;
  logic              accept;
  logic              misalign_req;
  logic              asm_we;
  logic [CNT_W-1:0]  asm_lane;

  // Upper PC bits fall outside the memory and are deliberately ignored.
  logic unused_pc_hi;
  assign unused_pc_hi = ^fetch_pc[31:ADDR_W];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, memory port steering and lane write selection.
  always_comb begin
    state_nxt    = state;
    mem_addr     = '0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    mem_wdata    = '0;
    load_ack     = 1'b0;
    accept       = 1'b0;
    misalign_req = 1'b0;
    asm_we       = 1'b0;
    asm_lane     = cnt - CNT_W'(1);
    case (state)
      IDLE: begin
        if (load_req) begin
          mem_we    = 1'b1;
          mem_addr  = load_addr;
          mem_wdata = load_byte;
          load_ack  = 1'b1;
        end else if (fetch_req) begin
          if (fetch_pc[1:0] == 2'b00) begin
            accept    = 1'b1;
            state_nxt = READ;
          end else begin
            misalign_req = 1'b1;
          end
        end
      end
      READ: begin
        mem_re   = 1'b1;
        mem_addr = base + ADDR_W'(cnt);
        // Read data trails the address by one cycle, so lane cnt-1 fills now.
        if (cnt != '0) asm_we = 1'b1;
        if (cnt == CNT_W'(BYTES_PER_INSTR - 1)) state_nxt = LAST;
      end
      LAST: begin
        asm_we    = 1'b1;
        asm_lane  = CNT_W'(BYTES_PER_INSTR - 1);
        state_nxt = HOLD;
      end
      HOLD: begin
        if (fetch_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset overrides every request, including the memory strobes.
    if (rst) begin
      mem_re   = 1'b0;
      mem_we   = 1'b0;
      load_ack = 1'b0;
    end
  end

  // Byte counter: restarts on accept, advances once per READ cycle.
  always_ff @(posedge clk) begin
    if (rst)                cnt <= '0;
    else if (accept)        cnt <= '0;
    else if (state == READ) cnt <= cnt + CNT_W'(1);
  end

  // Base address captured when a fetch is accepted.
  always_ff @(posedge clk) begin
    if (accept) base <= fetch_pc[ADDR_W-1:0];
  end

  // Misaligned request flag: a single-cycle pulse after the request.
  always_ff @(posedge clk) begin
    if (rst) misaligned <= 1'b0;
    else     misaligned <= misalign_req;
  end

  instr_byte_assembler u_asm (
    .clk  (clk),
    .clr  (rst),
    .we   (asm_we),
    .lane (asm_lane),
    .din  (mem_rdata),
    .word (instruction)
  );

  assign instr_valid = (state == HOLD);
  assign fetch_busy  = (state != IDLE);

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed bench for instr_fetch_sequencer with a transaction-level reference
// model and a per-cycle output comparison.
module tb_instr_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        fetch_ready;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        misaligned;
  logic        fetch_busy;
  logic        load_req;
  logic [6:0]  load_addr;
  logic [7:0]  load_byte;
  logic        load_ack;
  logic [6:0]  mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch_sequencer #(.ADDR_W(7)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready),
    .instruction(instruction), .instr_valid(instr_valid),
    .misaligned(misaligned), .fetch_busy(fetch_busy),
    .load_req(load_req), .load_addr(load_addr), .load_byte(load_byte),
    .load_ack(load_ack), .mem_addr(mem_addr), .mem_re(mem_re),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Byte memory attached to the DUT: synchronous read, one-cycle latency.
  logic [7:0] mem [128];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: idle / fetching (edges remaining) / holding a word.
  logic [7:0]  ref_mem [128];
  bit          m_idle  = 1'b1;
  int          m_left  = 0;
  bit          m_valid = 1'b0;
  bit          m_mis   = 1'b0;
  logic [31:0] m_instr = 32'h0;
  logic [6:0]  m_base  = 7'h0;

  function automatic logic [31:0] word_at(input logic [6:0] a);
    return {ref_mem[a], ref_mem[a + 7'd1], ref_mem[a + 7'd2], ref_mem[a + 7'd3]};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_idle = 1'b1; m_left = 0; m_valid = 1'b0; m_instr = 32'h0; m_mis = 1'b0;
    end else begin
      m_mis = 1'b0;
      if (m_idle) begin
        if (load_req) ref_mem[load_addr] = load_byte;
        else if (fetch_req) begin
          if (fetch_pc[1:0] == 2'b00) begin
            m_base = fetch_pc[6:0]; m_idle = 1'b0; m_left = 5;
          end else m_mis = 1'b1;
        end
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin m_valid = 1'b1; m_instr = word_at(m_base); end
      end else if (fetch_ready) begin
        m_valid = 1'b0; m_idle = 1'b1;
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  int re_cnt = 0;
  always @(negedge clk) begin
    bit exp_re, exp_we;
    exp_re = !m_idle && (m_left >= 2) && !rst;
    exp_we = m_idle && load_req && !rst;
    if (mem_re) re_cnt++;
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
    chk("fetch_busy", {31'b0, fetch_busy}, {31'b0, !m_idle});
    chk("misaligned", {31'b0, misaligned}, {31'b0, m_mis});
    if (m_idle || m_valid) chk("instruction", instruction, m_instr);
    chk("mem_re", {31'b0, mem_re}, {31'b0, exp_re});
    if (exp_re) chk("rd_addr", {25'b0, mem_addr}, {25'b0, m_base + 7'(5 - m_left)});
    chk("mem_we", {31'b0, mem_we}, {31'b0, exp_we});
    chk("load_ack", {31'b0, load_ack}, {31'b0, exp_we});
    if (exp_we) begin
      chk("wr_addr", {25'b0, mem_addr}, {25'b0, load_addr});
      chk("wr_data", {24'b0, mem_wdata}, {24'b0, load_byte});
    end
    chk("re_we_excl", {31'b0, mem_re & mem_we}, 32'h0);
  end

  task automatic do_load(input logic [6:0] a, input logic [7:0] d);
    load_req = 1'b1; load_addr = a; load_byte = d;
    #1 chk("load_ack_now", {31'b0, load_ack}, 32'h1);
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!instr_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    if (!instr_valid) chk("valid_timeout", {31'b0, instr_valid}, 32'h1);
  endtask

  task automatic do_fetch(input logic [31:0] pc, input int hold, output int lat);
    fetch_req = 1'b1; fetch_pc = pc;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    wait_valid(lat);
    for (int i = 0; i < hold; i++) begin @(posedge clk); #1; end
    fetch_ready = 1'b1;
    @(posedge clk); #1;
    fetch_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    rst = 1'b1; fetch_req = 1'b0; fetch_pc = '0; fetch_ready = 1'b0;
    load_req = 1'b0; load_addr = '0; load_byte = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_instruction", instruction, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_busy", {31'b0, fetch_busy}, 32'h0);

    do_load(7'h00, 8'h20); do_load(7'h01, 8'h08);
    do_load(7'h02, 8'h00); do_load(7'h03, 8'h05);
    do_load(7'h04, 8'hDE); do_load(7'h05, 8'hAD);
    do_load(7'h06, 8'hBE); do_load(7'h07, 8'hEF);
    do_load(7'h0A, 8'h0A); do_load(7'h0B, 8'h0B);
    do_load(7'h7C, 8'h11); do_load(7'h7D, 8'h22);
    do_load(7'h7E, 8'h33); do_load(7'h7F, 8'h44);

    // Basic fetch at pc 0.
    re_cnt = 0;
    do_fetch(32'h0, 0, lat);
    chk("lat_pc0", lat, 32'd5);
    chk("word_pc0", instruction, 32'h20080005);
    chk("re_cycles_pc0", re_cnt, 32'd4);

    // Held result with a load request blocked until IDLE.
    fetch_req = 1'b1; fetch_pc = 32'h4;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    wait_valid(lat);
    load_req = 1'b1; load_addr = 7'h08; load_byte = 8'h99;
    #1 chk("hold_load_ack", {31'b0, load_ack}, 32'h0);
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
    chk("hold_word", instruction, 32'hDEADBEEF);
    chk("hold_valid", {31'b0, instr_valid}, 32'h1);
    fetch_ready = 1'b1;
    @(posedge clk); #1;
    fetch_ready = 1'b0;
    chk("idle_load_ack", {31'b0, load_ack}, 32'h1);
    @(posedge clk); #1;
    load_req = 1'b0;

    // Load and fetch together: write first, fetch accepted next cycle.
    load_req = 1'b1; load_addr = 7'h09; load_byte = 8'h55;
    fetch_req = 1'b1; fetch_pc = 32'h8;
    #1 chk("both_re", {31'b0, mem_re}, 32'h0);
    @(posedge clk); #1;
    load_req = 1'b0;
    chk("both_not_busy", {31'b0, fetch_busy}, 32'h0);
    @(posedge clk); #1;
    fetch_req = 1'b0;
    chk("both_accepted", {31'b0, fetch_busy}, 32'h1);
    wait_valid(lat);
    chk("word_pc8", instruction, 32'h99550A0B);
    fetch_ready = 1'b1;
    @(posedge clk); #1;
    fetch_ready = 1'b0;

    // Misaligned request.
    re_cnt = 0;
    fetch_req = 1'b1; fetch_pc = 32'h6;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    chk("mis_pulse", {31'b0, misaligned}, 32'h1);
    @(posedge clk); #1;
    chk("mis_clear", {31'b0, misaligned}, 32'h0);
    chk("mis_word", instruction, 32'h99550A0B);
    chk("mis_no_re", re_cnt, 32'd0);

    // Top of memory and address wrap.
    do_fetch(32'h7C, 0, lat);
    chk("word_pc7c", instruction, 32'h11223344);
    do_fetch(32'h80, 0, lat);
    chk("word_pc80", instruction, 32'h20080005);

    // Reset while READ has reached byte 2.
    fetch_req = 1'b1; fetch_pc = 32'h0;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", {31'b0, fetch_busy}, 32'h0);
    chk("abort_valid", {31'b0, instr_valid}, 32'h0);
    chk("abort_word", instruction, 32'h0);
    do_fetch(32'h4, 2, lat);
    chk("after_abort_lat", lat, 32'd5);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
